pj_dmem_arbiter: RTL and testbench

PJ_DMEM_ARBITER -- requirements
Module: pj_dmem_arbiter

---
 rtl/Purple_Jade_pkg.sv | 15 +
 rtl/pj_rr_arb2.sv | 30 +++
 rtl/pj_dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_pj_dmem_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/Purple_Jade_pkg.sv
// Purple_Jade_pkg: types and constants shared by the data-memory arbiter
// and its round-robin helper.
package Purple_Jade_pkg;

  localparam int WORD_SIZE_P = 16;

  localparam int PORT_LSU    = 0;
  localparam int PORT_LOADER = 1;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } pj_dmem_arb_state_e;

endpackage

// File: rtl/pj_rr_arb2.sv
// pj_rr_arb2: two-way round-robin arbiter. When both requests are raised the
// pointer picks the winner and then moves to the losing port; a single
// request is granted directly and leaves the pointer alone.
module pj_rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  // Grant the pointed-to port on a contest, otherwise pass requests through
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After a contested grant, give priority to the port that lost
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= 1'b0;
    end else if (req_i == 2'b11) begin
      ptr_q <= ~ptr_q;
    end
  end

endmodule

// File: rtl/pj_dmem_arbiter.sv
// pj_dmem_arbiter: shares one data memory (separate sync-read and write
// ports) between the core LSU (port 0) and the loader/debug port (port 1).
// A read and a write from different ports go through together; same-kind
// requests are resolved round-robin; port 1 can lock the memory for itself.
// Optional stall counters are enabled with the macro PJ_DMEM_ARB_STATS_EN.
module pj_dmem_arbiter
  import Purple_Jade_pkg::*;
#(
  parameter int width_p = WORD_SIZE_P
) (
  input  logic               clk_i,
  input  logic               reset_i,

  input  logic               p0_v_i,
  input  logic               p0_w_i,
  input  logic [width_p-1:0] p0_addr_i,
  input  logic [width_p-1:0] p0_data_i,
  output logic               p0_ready_o,
  output logic               p0_resp_v_o,
  output logic [width_p-1:0] p0_resp_data_o,

  input  logic               p1_v_i,
  input  logic               p1_w_i,
  input  logic [width_p-1:0] p1_addr_i,
  input  logic [width_p-1:0] p1_data_i,
  output logic               p1_ready_o,
  output logic               p1_resp_v_o,
  output logic [width_p-1:0] p1_resp_data_o,

  input  logic               lock_i,
  output logic               locked_o,

  output logic               mem_w_v_o,
  output logic [width_p-1:0] mem_w_addr_o,
  output logic [width_p-1:0] mem_w_data_o,
  output logic               mem_r_v_o,
  output logic [width_p-1:0] mem_r_addr_o,
`ifdef PJ_DMEM_ARB_STATS_EN
  output logic [15:0]        stall_cnt0_o,
  output logic [15:0]        stall_cnt1_o,
`endif
  input  logic [width_p-1:0] mem_r_data_i
);

  pj_dmem_arb_state_e state_q;

  logic       p0_rd, p0_wr, p1_rd, p1_wr;
  logic       contest;
  logic       same_addr;
  logic [1:0] rr_grant;
  logic [1:0] rd_tag_q;

  assign p0_rd     = p0_v_i & ~p0_w_i;
  assign p0_wr     = p0_v_i &  p0_w_i;
  assign p1_rd     = p1_v_i & ~p1_w_i;
  assign p1_wr     = p1_v_i &  p1_w_i;
  assign same_addr = (p0_addr_i == p1_addr_i);

  // Two reads or two writes in ARB mode need the round-robin decision
  assign contest = ~reset_i & (state_q == ARB) &
                   ((p0_rd & p1_rd) | (p0_wr & p1_wr));

  pj_rr_arb2 u_rr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   ({contest, contest}),
    .grant_o (rr_grant)
  );

  // Lock FSM: the lock request is honoured from the following cycle on
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ARB;
      locked_o <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (lock_i) begin
            state_q  <= LOCKED;
            locked_o <= 1'b1;
          end
        end
        LOCKED: begin
          if (!lock_i) begin
            state_q  <= ARB;
            locked_o <= 1'b0;
          end
        end
        default: begin
          state_q  <= ARB;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

  // Grant decision; a read colliding with a write to the same word waits
  always_comb begin
    p0_ready_o = 1'b0;
    p1_ready_o = 1'b0;
    if (!reset_i) begin
      if (state_q == LOCKED) begin
        p1_ready_o = p1_v_i;
      end else if (contest) begin
        p0_ready_o = rr_grant[PORT_LSU];
        p1_ready_o = rr_grant[PORT_LOADER];
      end else if (p0_rd & p1_wr) begin
        p1_ready_o = 1'b1;
        p0_ready_o = ~same_addr;
      end else if (p0_wr & p1_rd) begin
        p0_ready_o = 1'b1;
        p1_ready_o = ~same_addr;
      end else begin
        p0_ready_o = p0_v_i;
        p1_ready_o = p1_v_i;
      end
    end
  end

  // Steer the granted write and the granted read onto the memory ports
  always_comb begin
    mem_w_v_o    = 1'b0;
    mem_w_addr_o = p0_addr_i;
    mem_w_data_o = p0_data_i;
    mem_r_v_o    = 1'b0;
    mem_r_addr_o = p0_addr_i;
    if (p0_ready_o & p0_w_i) begin
      mem_w_v_o = 1'b1;
    end else if (p1_ready_o & p1_w_i) begin
      mem_w_v_o    = 1'b1;
      mem_w_addr_o = p1_addr_i;
      mem_w_data_o = p1_data_i;
    end
    if (p0_ready_o & ~p0_w_i) begin
      mem_r_v_o = 1'b1;
    end else if (p1_ready_o & ~p1_w_i) begin
      mem_r_v_o    = 1'b1;
      mem_r_addr_o = p1_addr_i;
    end
  end

  // Remember which port owns the read data arriving next cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_tag_q <= 2'b00;
    end else begin
      rd_tag_q <= {p1_ready_o & ~p1_w_i, p0_ready_o & ~p0_w_i};
    end
  end

  assign p0_resp_v_o    = rd_tag_q[PORT_LSU]    & ~reset_i;
  assign p1_resp_v_o    = rd_tag_q[PORT_LOADER] & ~reset_i;
  assign p0_resp_data_o = mem_r_data_i;
  assign p1_resp_data_o = mem_r_data_i;

`ifdef PJ_DMEM_ARB_STATS_EN
  // Count cycles each port waits with a valid request, saturating at max
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt0_o <= 16'h0000;
      stall_cnt1_o <= 16'h0000;
    end else begin
      if (p0_v_i && !p0_ready_o && stall_cnt0_o != 16'hFFFF) begin
        stall_cnt0_o <= stall_cnt0_o + 16'h0001;
      end
      if (p1_v_i && !p1_ready_o && stall_cnt1_o != 16'hFFFF) begin
        stall_cnt1_o <= stall_cnt1_o + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pj_dmem_arbiter.sv
// tb_pj_dmem_arbiter: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the arbitration rules and memory.
module tb_pj_dmem_arbiter;
  import Purple_Jade_pkg::*;

  localparam int W = WORD_SIZE_P;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         p0_v_i, p0_w_i, p1_v_i, p1_w_i, lock_i;
  logic [W-1:0] p0_addr_i, p0_data_i, p1_addr_i, p1_data_i;
  logic         p0_ready_o, p1_ready_o, p0_resp_v_o, p1_resp_v_o, locked_o;
  logic [W-1:0] p0_resp_data_o, p1_resp_data_o;
  logic         mem_w_v_o, mem_r_v_o;
  logic [W-1:0] mem_w_addr_o, mem_w_data_o, mem_r_addr_o;
  logic [W-1:0] mem_r_data_i;
`ifdef PJ_DMEM_ARB_STATS_EN
  logic [15:0]  stall_cnt0_o, stall_cnt1_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pj_dmem_arbiter #(.width_p(W)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .p0_v_i         (p0_v_i),
    .p0_w_i         (p0_w_i),
    .p0_addr_i      (p0_addr_i),
    .p0_data_i      (p0_data_i),
    .p0_ready_o     (p0_ready_o),
    .p0_resp_v_o    (p0_resp_v_o),
    .p0_resp_data_o (p0_resp_data_o),
    .p1_v_i         (p1_v_i),
    .p1_w_i         (p1_w_i),
    .p1_addr_i      (p1_addr_i),
    .p1_data_i      (p1_data_i),
    .p1_ready_o     (p1_ready_o),
    .p1_resp_v_o    (p1_resp_v_o),
    .p1_resp_data_o (p1_resp_data_o),
    .lock_i         (lock_i),
    .locked_o       (locked_o),
    .mem_w_v_o      (mem_w_v_o),
    .mem_w_addr_o   (mem_w_addr_o),
    .mem_w_data_o   (mem_w_data_o),
    .mem_r_v_o      (mem_r_v_o),
    .mem_r_addr_o   (mem_r_addr_o),
`ifdef PJ_DMEM_ARB_STATS_EN
    .stall_cnt0_o   (stall_cnt0_o),
    .stall_cnt1_o   (stall_cnt1_o),
`endif
    .mem_r_data_i   (mem_r_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read memory attached to the DUT's memory ports
  logic [W-1:0] hw_mem [256];
  always @(posedge clk_i) begin
    if (mem_r_v_o) mem_r_data_i <= hw_mem[mem_r_addr_o[7:0]];
    if (mem_w_v_o) hw_mem[mem_w_addr_o[7:0]] <= mem_w_data_o;
  end

  // Reference model state
  logic [W-1:0] ref_mem [256];
  bit           m_locked;
  int           m_ptr;
  bit           m_pend_v [2];
  logic [W-1:0] m_pend_d [2];
  int           m_stall  [2];

  // Which ports the rules grant this cycle, given model state and inputs
  function automatic void exp_grants(output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset_i) return;
    if (m_locked) begin
      g1 = p1_v_i;
    end else if (!(p0_v_i && p1_v_i)) begin
      g0 = p0_v_i;
      g1 = p1_v_i;
    end else if (p0_w_i == p1_w_i) begin
      g0 = (m_ptr == 0);
      g1 = (m_ptr == 1);
    end else if (p0_addr_i == p1_addr_i) begin
      g0 = p0_w_i;
      g1 = p1_w_i;
    end else begin
      g0 = 1'b1;
      g1 = 1'b1;
    end
  endfunction

  // Apply this cycle's transactions to the model, then move to next cycle
  task automatic tick();
    bit g0, g1;
    bit nv0 = 1'b0, nv1 = 1'b0;
    logic [W-1:0] nd0 = '0, nd1 = '0;
    exp_grants(g0, g1);
    if (reset_i) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_stall[0] = 0;
      m_stall[1] = 0;
    end else begin
      if (g0 && !p0_w_i) begin nv0 = 1'b1; nd0 = ref_mem[p0_addr_i[7:0]]; end
      if (g1 && !p1_w_i) begin nv1 = 1'b1; nd1 = ref_mem[p1_addr_i[7:0]]; end
      if (g0 && p0_w_i) ref_mem[p0_addr_i[7:0]] = p0_data_i;
      if (g1 && p1_w_i) ref_mem[p1_addr_i[7:0]] = p1_data_i;
      if (!m_locked && p0_v_i && p1_v_i && p0_w_i == p1_w_i) m_ptr = 1 - m_ptr;
      if (p0_v_i && !g0 && m_stall[0] < 65535) m_stall[0]++;
      if (p1_v_i && !g1 && m_stall[1] < 65535) m_stall[1]++;
      m_locked = lock_i;
    end
    m_pend_v[0] = nv0; m_pend_d[0] = nd0;
    m_pend_v[1] = nv1; m_pend_d[1] = nd1;
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    p0_v_i = 0; p0_w_i = 0; p0_addr_i = '0; p0_data_i = '0;
    p1_v_i = 0; p1_w_i = 0; p1_addr_i = '0; p1_data_i = '0;
    lock_i = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    reset_i = 1'b1;
    p0_v_i = 1; p0_w_i = 1; p0_addr_i = 16'h0003; p0_data_i = 16'h1111;
    p1_v_i = 1; p1_w_i = 0; p1_addr_i = 16'h0004; lock_i = 1;
    #2;
    n_checks++;
    if ({p0_ready_o, p1_ready_o} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b expected 00", {p0_ready_o, p1_ready_o});
    end
    n_checks++;
    if ({mem_w_v_o, mem_r_v_o} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_mem_v: got %b expected 00", {mem_w_v_o, mem_r_v_o});
    end
    tick();
    #2;
    n_checks++;
    ok = ({p0_resp_v_o, p1_resp_v_o, locked_o} === 3'b000);
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL reset_resp_lock: got %b expected 000",
               {p0_resp_v_o, p1_resp_v_o, locked_o});
    end
`ifdef PJ_DMEM_ARB_STATS_EN
    n_checks++;
    if ({stall_cnt0_o, stall_cnt1_o} !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_stats: got %h/%h expected 0/0", stall_cnt0_o, stall_cnt1_o);
    end
`endif
    tick();
    reset_i = 1'b0;
    idle_inputs();
  endtask

  task automatic test_concurrent_rw();
    logic [W-1:0] exp_d;
    reset_dut();
    exp_d = ref_mem[8'h10];
    p0_v_i = 1; p0_w_i = 0; p0_addr_i = 16'h0010;
    p1_v_i = 1; p1_w_i = 1; p1_addr_i = 16'h0020; p1_data_i = 16'hBEEF;
    #2;
    n_checks++;
    if ({p0_ready_o, p1_ready_o} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL rw_ready: got %b expected 11", {p0_ready_o, p1_ready_o});
    end
    n_checks++;
    if ({mem_w_v_o, mem_r_v_o} !== 2'b11 || mem_w_data_o !== 16'hBEEF) begin
      n_fail++;
      $display("[TB] FAIL rw_mem_ports: got v=%b wd=%h expected v=11 wd=beef",
               {mem_w_v_o, mem_r_v_o}, mem_w_data_o);
    end
    tick();
    idle_inputs();
    #2;
    n_checks++;
    if (p0_resp_v_o !== 1'b1 || p1_resp_v_o !== 1'b0 || p0_resp_data_o !== exp_d) begin
      n_fail++;
      $display("[TB] FAIL rw_resp: got v=%b%b d=%h expected v=10 d=%h",
               p0_resp_v_o, p1_resp_v_o, p0_resp_data_o, exp_d);
    end
    tick();
    p0_v_i = 1; p0_w_i = 0; p0_addr_i = 16'h0020;
    tick();
    idle_inputs();
    #2;
    n_checks++;
    if (p0_resp_v_o !== 1'b1 || p0_resp_data_o !== 16'hBEEF) begin
      n_fail++;
      $display("[TB] FAIL rw_readback: got v=%b d=%h expected v=1 d=beef",
               p0_resp_v_o, p0_resp_data_o);
    end
    tick();
  endtask

  task automatic test_read_alternation();
    bit prev0 = 0, prev1 = 0;
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        p0_v_i = 1; p0_w_i = 0; p0_addr_i = 16'h0011;
        p1_v_i = 1; p1_w_i = 0; p1_addr_i = 16'h0022;
      end else begin
        idle_inputs();
      end
      #2;
      if (i < 4) begin
        n_checks++;
        if (p0_ready_o !== (i % 2 == 0) || p1_ready_o !== (i % 2 == 1)) begin
          n_fail++;
          $display("[TB] FAIL alt_grant cycle %0d: got %b%b expected %b%b", i,
                   p0_ready_o, p1_ready_o, (i % 2 == 0), (i % 2 == 1));
        end
      end
      n_checks++;
      if (p0_resp_v_o !== prev0 || p1_resp_v_o !== prev1) begin
        n_fail++;
        $display("[TB] FAIL alt_resp cycle %0d: got %b%b expected %b%b", i,
                 p0_resp_v_o, p1_resp_v_o, prev0, prev1);
      end
      prev0 = (i < 4) && (i % 2 == 0);
      prev1 = (i < 4) && (i % 2 == 1);
      tick();
    end
  endtask

  task automatic test_raw_collision();
    reset_dut();
    p0_v_i = 1; p0_w_i = 0; p0_addr_i = 16'h0040;
    p1_v_i = 1; p1_w_i = 1; p1_addr_i = 16'h0040; p1_data_i = 16'h1234;
    #2;
    n_checks++;
    if ({p0_ready_o, p1_ready_o} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL raw_first: got %b expected 01", {p0_ready_o, p1_ready_o});
    end
    tick();
    p1_v_i = 0; p1_w_i = 0;
    #2;
    n_checks++;
    if (p0_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL raw_retry: got %b expected 1", p0_ready_o);
    end
    tick();
    idle_inputs();
    #2;
    n_checks++;
    if (p0_resp_v_o !== 1'b1 || p0_resp_data_o !== 16'h1234) begin
      n_fail++;
      $display("[TB] FAIL raw_data: got v=%b d=%h expected v=1 d=1234",
               p0_resp_v_o, p0_resp_data_o);
    end
    tick();
  endtask

  task automatic test_lock();
    bit exp_locked;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      p0_v_i = 1; p0_w_i = 0; p0_addr_i = 16'h0030;
      lock_i = (i < 5);
      exp_locked = (i >= 1 && i <= 5);
      #2;
      n_checks++;
      if (locked_o !== exp_locked || p0_ready_o !== !exp_locked) begin
        n_fail++;
        $display("[TB] FAIL lock cycle %0d: got locked=%b p0_ready=%b expected %b/%b",
                 i, locked_o, p0_ready_o, exp_locked, !exp_locked);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_discard();
    reset_dut();
    p1_v_i = 1; p1_w_i = 0; p1_addr_i = 16'h0050;
    #2;
    n_checks++;
    if (p1_ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL discard_grant: got %b expected 1", p1_ready_o);
    end
    tick();
    idle_inputs();
    reset_i = 1'b1;
    #2;
    n_checks++;
    if ({p0_ready_o, p1_ready_o, p0_resp_v_o, p1_resp_v_o, mem_w_v_o, mem_r_v_o, locked_o} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL discard_in_reset: got %b expected 0000000",
               {p0_ready_o, p1_ready_o, p0_resp_v_o, p1_resp_v_o, mem_w_v_o, mem_r_v_o, locked_o});
    end
    tick();
    reset_i = 1'b0;
    #2;
    n_checks++;
    if (p1_resp_v_o !== 1'b0 || p0_resp_v_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL discard_after: got %b%b expected 00", p0_resp_v_o, p1_resp_v_o);
    end
    tick();
  endtask

  task automatic test_random();
    bit g0, g1;
    int errs = 0;
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      p0_v_i = ($urandom_range(0, 3) != 0);
      p0_w_i = $urandom_range(0, 1);
      p0_addr_i = 16'($urandom_range(0, 7));
      p0_data_i = 16'($urandom);
      p1_v_i = ($urandom_range(0, 3) != 0);
      p1_w_i = $urandom_range(0, 1);
      p1_addr_i = 16'($urandom_range(0, 7));
      p1_data_i = 16'($urandom);
      if ($urandom_range(0, 15) == 0) lock_i = ~lock_i;
      #2;
      exp_grants(g0, g1);
      n_checks++;
      if (p0_ready_o !== g0 || p1_ready_o !== g1 || locked_o !== m_locked ||
          mem_w_v_o !== ((g0 && p0_w_i) || (g1 && p1_w_i)) ||
          mem_r_v_o !== ((g0 && !p0_w_i) || (g1 && !p1_w_i))) begin
        n_fail++;
        if (errs++ < 10)
          $display("[TB] FAIL rand_grant cycle %0d: got rdy=%b%b lk=%b wv=%b rv=%b expected rdy=%b%b lk=%b",
                   i, p0_ready_o, p1_ready_o, locked_o, mem_w_v_o, mem_r_v_o, g0, g1, m_locked);
      end
      n_checks++;
      if (p0_resp_v_o !== m_pend_v[0] || p1_resp_v_o !== m_pend_v[1] ||
          (m_pend_v[0] && p0_resp_data_o !== m_pend_d[0]) ||
          (m_pend_v[1] && p1_resp_data_o !== m_pend_d[1])) begin
        n_fail++;
        if (errs++ < 10)
          $display("[TB] FAIL rand_resp cycle %0d: got v=%b%b d=%h/%h expected v=%b%b d=%h/%h",
                   i, p0_resp_v_o, p1_resp_v_o, p0_resp_data_o, p1_resp_data_o,
                   m_pend_v[0], m_pend_v[1], m_pend_d[0], m_pend_d[1]);
      end
      tick();
    end
`ifdef PJ_DMEM_ARB_STATS_EN
    n_checks++;
    if (int'(stall_cnt0_o) != m_stall[0] || int'(stall_cnt1_o) != m_stall[1]) begin
      n_fail++;
      $display("[TB] FAIL rand_stats: got %0d/%0d expected %0d/%0d",
               stall_cnt0_o, stall_cnt1_o, m_stall[0], m_stall[1]);
    end
`endif
    idle_inputs();
    tick();
  endtask

`ifdef PJ_DMEM_ARB_STATS_EN
  task automatic test_stats_saturation();
    reset_dut();
    p0_v_i = 1; p0_w_i = 1; p0_addr_i = 16'h0005; p0_data_i = 16'h5555;
    p1_v_i = 1; p1_w_i = 0; p1_addr_i = 16'h0005;
    for (int i = 0; i < 70000; i++) begin
      if (i == 65534) begin
        #2;
        n_checks++;
        if (stall_cnt1_o !== 16'hFFFE) begin
          n_fail++;
          $display("[TB] FAIL stats_near_max: got %h expected fffe", stall_cnt1_o);
        end
      end
      tick();
    end
    #2;
    n_checks++;
    if (stall_cnt1_o !== 16'hFFFF || stall_cnt0_o !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL stats_saturate: got %h/%h expected 0000/ffff",
               stall_cnt0_o, stall_cnt1_o);
    end
    idle_inputs();
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'hA500 ^ 16'(i);
      hw_mem[i]  = 16'hA500 ^ 16'(i);
    end
    mem_r_data_i = '0;
    m_locked = 0; m_ptr = 0;
    m_pend_v[0] = 0; m_pend_v[1] = 0;
    m_pend_d[0] = '0; m_pend_d[1] = '0;
    m_stall[0] = 0; m_stall[1] = 0;
    idle_inputs();
    reset_i = 1'b1;
    @(negedge clk_i);
    $display("[TB] starting pj_dmem_arbiter bench");
    test_reset();
    test_concurrent_rw();
    test_read_alternation();
    test_raw_collision();
    test_lock();
    test_reset_discard();
    test_random();
`ifdef PJ_DMEM_ARB_STATS_EN
    test_stats_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
